// File: rtl/membus_arb2.sv
// Round-robin arbiter: two masters share one split-transaction slave bus.
// Read issuers are queued in an in-order ID FIFO so responses return to the right master.
module membus_arb2 #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,

  input  logic                         m0_req_i,
  input  logic                         m0_we_i,
  input  logic [ADDR_W-1:0]            m0_addr_bi,
  input  logic [DATA_W/8-1:0]          m0_be_bi,
  input  logic [DATA_W-1:0]            m0_wdata_bi,
  output logic                         m0_ack_o,
  output logic                         m0_resp_o,
  output logic [DATA_W-1:0]            m0_rdata_bo,

  input  logic                         m1_req_i,
  input  logic                         m1_we_i,
  input  logic [ADDR_W-1:0]            m1_addr_bi,
  input  logic [DATA_W/8-1:0]          m1_be_bi,
  input  logic [DATA_W-1:0]            m1_wdata_bi,
  output logic                         m1_ack_o,
  output logic                         m1_resp_o,
  output logic [DATA_W-1:0]            m1_rdata_bo,

  output logic                         s_req_o,
  output logic                         s_we_o,
  output logic [ADDR_W-1:0]            s_addr_bo,
  output logic [DATA_W/8-1:0]          s_be_bo,
  output logic [DATA_W-1:0]            s_wdata_bo,
  input  logic                         s_ack_i,
  input  logic                         s_resp_i,
  input  logic [DATA_W-1:0]            s_rdata_bi,

  output logic [$clog2(MAX_OUTST):0]   outst_bo,
  output logic                         stray_resp_o
);

  localparam int CNT_W = $clog2(MAX_OUTST) + 1;
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTST);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTST - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             id_mem_q [MAX_OUTST];
  logic             rr_last_q;
  logic             stray_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             push;
  logic             accept;
  logic             head_id;
  logic             m0_elig;
  logic             m1_elig;
  logic             gnt_vld;
  logic             gnt_id;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full  = (cnt_q == FULL_CNT);
  assign fifo_empty = (cnt_q == '0);
  assign pop        = s_resp_i & ~fifo_empty;
  assign head_id    = id_mem_q[rd_ptr_q];

  // A read is held back only while the FIFO is full and no response frees a slot
  // this cycle; a write from either master is never held back by the FIFO.
  assign m0_elig = m0_req_i & (m0_we_i | ~fifo_full | s_resp_i);
  assign m1_elig = m1_req_i & (m1_we_i | ~fifo_full | s_resp_i);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (m0_elig && m1_elig) begin
      gnt_vld = 1'b1;
      gnt_id  = ~rr_last_q;
    end else if (m0_elig) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b0;
    end else if (m1_elig) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b1;
    end
  end

  always_comb begin
    s_req_o    = 1'b0;
    s_we_o     = 1'b0;
    s_addr_bo  = '0;
    s_be_bo    = '0;
    s_wdata_bo = '0;
    // Nothing is forwarded while reset is held, so no handshake can slip through.
    if (gnt_vld && rst_ni) begin
      s_req_o = 1'b1;
      if (gnt_id) begin
        s_we_o     = m1_we_i;
        s_addr_bo  = m1_addr_bi;
        s_be_bo    = m1_be_bi;
        s_wdata_bo = m1_wdata_bi;
      end else begin
        s_we_o     = m0_we_i;
        s_addr_bo  = m0_addr_bi;
        s_be_bo    = m0_be_bi;
        s_wdata_bo = m0_wdata_bi;
      end
    end
  end

  assign accept   = s_req_o & s_ack_i;
  assign push     = accept & ~s_we_o;
  assign m0_ack_o = accept & ~gnt_id;
  assign m1_ack_o = accept &  gnt_id;

  always_comb begin
    m0_resp_o   = 1'b0;
    m1_resp_o   = 1'b0;
    m0_rdata_bo = '0;
    m1_rdata_bo = '0;
    if (pop) begin
      if (head_id) begin
        m1_resp_o   = 1'b1;
        m1_rdata_bo = s_rdata_bi;
      end else begin
        m0_resp_o   = 1'b1;
        m0_rdata_bo = s_rdata_bi;
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_last_q <= 1'b1;
      stray_q   <= 1'b0;
    end else begin
      if (accept) rr_last_q <= gnt_id;
      if (s_resp_i && fifo_empty) stray_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: the ID storage has no reset; only entries between the reset-cleared
  // pointers are ever read, so stale contents are harmless.
  always_ff @(posedge clk_i) begin
    if (push) id_mem_q[wr_ptr_q] <= gnt_id;
  end

  assign outst_bo     = cnt_q;
  assign stray_resp_o = stray_q;

endmodule
